// File: rtl/forward_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// forward_stall_ctrl_pkg
//   Shared constants for the execute-stage forwarding / load-use stall control:
//   ALU source select encodings, the bit layout of an EX/MEM tracker entry and
//   the stall FSM state type.
// -----------------------------------------------------------------------------
package forward_stall_ctrl_pkg;

   // ALUsrc encodings driven to the EX operand muxes
   localparam logic [1:0] ALU_SRC_REG      = 2'b00;
   localparam logic [1:0] ALU_SRC_PREV_ALU = 2'b01;
   localparam logic [1:0] ALU_SRC_PREV_MEM = 2'b10;

   // Tracker entry layout: {dst[REG_AW-1:0], v, load, wr}
   // The destination field sits on top so its width can follow REG_AW.
   localparam int TRK_WR_BIT  = 0;
   localparam int TRK_LD_BIT  = 1;
   localparam int TRK_V_BIT   = 2;
   localparam int TRK_DST_LSB = 3;

   // Load-use stall FSM
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } fsm_state_e;

   // Total tracker entry width for a given register-index width
   function automatic int trk_width(input int reg_aw);
      return reg_aw + TRK_DST_LSB;
   endfunction

endpackage

// File: rtl/forward_stall_ctrl_fwd_src_pick.sv
// -----------------------------------------------------------------------------
// fwd_src_pick
//   Chooses the bypass source for one ID operand by comparing it with the
//   instructions currently in EX and MEM (youngest first).
//   Ports:
//     src_i       operand register index
//     used_i      operand actually reads a register
//     ex_t_i      tracker entry of the instruction in EX
//     mem_t_i     tracker entry of the instruction in MEM
//     sel_o       ALUsrc select (REG / PREV_ALU / PREV_MEM)
//     load_hit_o  operand needs a load result that is still in EX
// -----------------------------------------------------------------------------
module fwd_src_pick
   import forward_stall_ctrl_pkg::*;
#(
   parameter int REG_AW = 3
) (
   input  logic [REG_AW-1:0]             src_i,
   input  logic                          used_i,
   input  logic [REG_AW+TRK_DST_LSB-1:0] ex_t_i,
   input  logic [REG_AW+TRK_DST_LSB-1:0] mem_t_i,
   output logic [1:0]                    sel_o,
   output logic                          load_hit_o
);

   localparam int TW = REG_AW + TRK_DST_LSB;

   logic ex_match;
   logic mem_match;
   logic mem_ld_unused;

   assign ex_match  = used_i & ex_t_i[TRK_V_BIT] & ex_t_i[TRK_WR_BIT] &
                      (ex_t_i[TW-1:TRK_DST_LSB] == src_i);
   assign mem_match = used_i & mem_t_i[TRK_V_BIT] & mem_t_i[TRK_WR_BIT] &
                      (mem_t_i[TW-1:TRK_DST_LSB] == src_i);

   // A load in MEM has its data at the MEM output, so it forwards like any
   // other MEM-stage result; its load flag plays no role here.
   assign mem_ld_unused = mem_t_i[TRK_LD_BIT];

   // EX is checked first: when both stages write the register, EX is newer.
   always_comb begin
      sel_o      = ALU_SRC_REG;
      load_hit_o = 1'b0;
      if (ex_match) begin
         if (ex_t_i[TRK_LD_BIT]) begin
            load_hit_o = 1'b1;
         end else begin
            sel_o = ALU_SRC_PREV_ALU;
         end
      end else if (mem_match) begin
         sel_o = ALU_SRC_PREV_MEM;
      end
   end

endmodule

// File: rtl/forward_stall_ctrl.sv
// -----------------------------------------------------------------------------
// forward_stall_ctrl
//   Execute-stage operand bypass and load-use stall control.
//   Shadows the destination/load info of the instructions in EX and MEM,
//   computes ALUsrc1/ALUsrc2 for the instruction leaving ID and registers them
//   so they line up with EX, stalls IF/ID and injects EX bubbles on load-use
//   hazards, and counts stall cycles with a saturating counter.
//   Ports:
//     clk, rst                 clock (rising edge), async active-high reset
//     id_valid                 ID holds a real instruction
//     id_src1/_used            operand-1 register index / reads a register
//     id_src2/_used            operand-2 register index / reads a register
//     id_dst, id_wr_en         destination register / writes it
//     id_is_load               result only available at MEM output
//     ex_flush                 taken branch/jump resolved in EX
//     alu_src1, alu_src2       registered operand selects for EX
//     stall                    hold PC and IF/ID (combinational)
//     ex_bubble                registered; EX holds an injected NOP
//     stall_cycles             saturating count of stall cycles
// -----------------------------------------------------------------------------
module forward_stall_ctrl
   import forward_stall_ctrl_pkg::*;
#(
   parameter int REG_AW          = 3,
   parameter int LOAD_USE_STALLS = 1,
   parameter int STALL_CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [REG_AW-1:0]      id_src1,
   input  logic                   id_src1_used,
   input  logic [REG_AW-1:0]      id_src2,
   input  logic                   id_src2_used,
   input  logic [REG_AW-1:0]      id_dst,
   input  logic                   id_wr_en,
   input  logic                   id_is_load,
   input  logic                   ex_flush,
   output logic [1:0]             alu_src1,
   output logic [1:0]             alu_src2,
   output logic                   stall,
   output logic                   ex_bubble,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam int         TW       = REG_AW + TRK_DST_LSB;
   // Remaining stall cycles once the first (IDLE-state) stall has been taken
   localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_STALLS - 1);

   // ---------------------------------------------------------------- state
   logic [TW-1:0]          ex_t_q,  ex_t_d;
   logic [TW-1:0]          mem_t_q, mem_t_d;
   fsm_state_e             state_q, state_d;
   logic [1:0]             cnt_q,   cnt_d;
   logic [1:0]             src1_q,  src1_d;
   logic [1:0]             src2_q,  src2_d;
   logic                   bubble_q, bubble_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // ---------------------------------------------------------------- comb
   logic [TW-1:0] id_t;
   logic [1:0]    sel1, sel2;
   logic          hit1, hit2;
   logic          load_hit;
   logic          stall_c;
   logic          advance;

   // Tracker entry for the instruction in ID, in the package layout
   assign id_t = {id_dst, 1'b1, id_is_load, id_wr_en};

   fwd_src_pick #(
      .REG_AW (REG_AW)
   ) u_pick1 (
      .src_i      (id_src1),
      .used_i     (id_src1_used),
      .ex_t_i     (ex_t_q),
      .mem_t_i    (mem_t_q),
      .sel_o      (sel1),
      .load_hit_o (hit1)
   );

   fwd_src_pick #(
      .REG_AW (REG_AW)
   ) u_pick2 (
      .src_i      (id_src2),
      .used_i     (id_src2_used),
      .ex_t_i     (ex_t_q),
      .mem_t_i    (mem_t_q),
      .sel_o      (sel2),
      .load_hit_o (hit2)
   );

   assign load_hit = id_valid & (hit1 | hit2);

   // Stall FSM. IDLE stalls combinationally on a fresh hit; with more than
   // one bubble per hazard, STALL covers the remaining cycles regardless of
   // what ID shows. A flush cancels everything in the same cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_hit) begin
               stall_c = 1'b1;
               if (LOAD_USE_STALLS > 1) begin
                  state_d = ST_STALL;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ST_STALL: begin
            stall_c = 1'b1;
            if (cnt_q == 2'd1) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (ex_flush) begin
         stall_c = 1'b0;
         state_d = ST_IDLE;
      end
   end

   assign advance = id_valid & ~stall_c & ~ex_flush;

   always_comb begin
      mem_t_d     = ex_t_q;
      ex_t_d      = advance ? id_t : '0;
      src1_d      = advance ? sel1 : ALU_SRC_REG;
      src2_d      = advance ? sel2 : ALU_SRC_REG;
      bubble_d    = ~advance;
      stall_cnt_d = stall_cnt_q;
      if (stall_c && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------- ID -> EX boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_t_q      <= '0;
         mem_t_q     <= '0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         src1_q      <= ALU_SRC_REG;
         src2_q      <= ALU_SRC_REG;
         bubble_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         ex_t_q      <= ex_t_d;
         mem_t_q     <= mem_t_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         src1_q      <= src1_d;
         src2_q      <= src2_d;
         bubble_q    <= bubble_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign alu_src1     = src1_q;
   assign alu_src2     = src2_q;
   assign stall        = stall_c;
   assign ex_bubble    = bubble_q;
   assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_forward_stall_ctrl.sv
// Three instances share one stimulus stream: N=1, N=3, and N=3 with a narrow
// counter so saturation is reachable in a short run. A behavioural pipeline
// model (two instruction slots plus a remaining-stall count per instance)
// predicts every output.
module tb_forward_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       id_valid, id_src1_used, id_src2_used, id_wr_en, id_is_load, ex_flush;
   logic [2:0] id_src1, id_src2, id_dst;

   logic [1:0]  src1_o [3];
   logic [1:0]  src2_o [3];
   logic        stall_o [3];
   logic        bub_o [3];
   logic [15:0] cnt0, cnt1;
   logic [3:0]  cnt2;

   always #5 clk = ~clk;

   forward_stall_ctrl #(.REG_AW(3), .LOAD_USE_STALLS(1), .STALL_CNT_W(16)) u_n1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
      .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dst(id_dst), .id_wr_en(id_wr_en),
      .id_is_load(id_is_load), .ex_flush(ex_flush), .alu_src1(src1_o[0]), .alu_src2(src2_o[0]),
      .stall(stall_o[0]), .ex_bubble(bub_o[0]), .stall_cycles(cnt0));

   forward_stall_ctrl #(.REG_AW(3), .LOAD_USE_STALLS(3), .STALL_CNT_W(16)) u_n3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
      .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dst(id_dst), .id_wr_en(id_wr_en),
      .id_is_load(id_is_load), .ex_flush(ex_flush), .alu_src1(src1_o[1]), .alu_src2(src2_o[1]),
      .stall(stall_o[1]), .ex_bubble(bub_o[1]), .stall_cycles(cnt1));

   forward_stall_ctrl #(.REG_AW(3), .LOAD_USE_STALLS(3), .STALL_CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
      .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dst(id_dst), .id_wr_en(id_wr_en),
      .id_is_load(id_is_load), .ex_flush(ex_flush), .alu_src1(src1_o[2]), .alu_src2(src2_o[2]),
      .stall(stall_o[2]), .ex_bubble(bub_o[2]), .stall_cycles(cnt2));

   // ------------------------------------------------------------ model
   typedef struct {
      bit v;
      int dst;
      bit wr;
      bit ld;
   } slot_t;

   slot_t m_ex [3];
   slot_t m_mem [3];
   int    m_left [3];
   int    m_cnt [3];
   int    m_s1 [3];
   int    m_s2 [3];
   int    m_bub [3];
   int    last_stall [3];
   int    NN [3]   = '{1, 3, 3};
   int    CMAX [3] = '{65535, 65535, 15};

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int obs_cnt(input int k);
      case (k)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   // Where an operand's value comes from next cycle, judged from which older
   // in-flight instruction last wrote that register.
   function automatic int fwd(input int k, input int s, input bit used);
      if (!used) return 0;
      if (m_ex[k].v && m_ex[k].wr && m_ex[k].dst == s) return m_ex[k].ld ? 0 : 1;
      if (m_mem[k].v && m_mem[k].wr && m_mem[k].dst == s) return 2;
      return 0;
   endfunction

   function automatic bit luh(input int k, input int s, input bit used);
      return used && m_ex[k].v && m_ex[k].wr && m_ex[k].ld && m_ex[k].dst == s;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_ex[k].v = 0;  m_ex[k].dst = 0;  m_ex[k].wr = 0;  m_ex[k].ld = 0;
         m_mem[k].v = 0; m_mem[k].dst = 0; m_mem[k].wr = 0; m_mem[k].ld = 0;
         m_left[k] = 0; m_cnt[k] = 0; m_s1[k] = 0; m_s2[k] = 0; m_bub[k] = 0;
      end
   endtask

   task automatic set_id(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                         input int d, input bit wr, input bit ld, input bit fl);
      id_valid = v;  id_src1 = 3'(s1); id_src1_used = u1;
      id_src2 = 3'(s2); id_src2_used = u2;
      id_dst = 3'(d); id_wr_en = wr; id_is_load = ld; ex_flush = fl;
   endtask

   // Called shortly after a rising edge with inputs already applied.
   task automatic step();
      bit st [3];
      bit h [3];
      bit adv;
      #2;
      for (int k = 0; k < 3; k++) begin
         h[k]  = id_valid && (luh(k, int'(id_src1), id_src1_used) || luh(k, int'(id_src2), id_src2_used));
         st[k] = !ex_flush && (m_left[k] > 0 || h[k]);
         last_stall[k] = int'(stall_o[k]);
         chk($sformatf("stall[%0d]", k), int'(stall_o[k]), int'(st[k]));
      end
      for (int k = 0; k < 3; k++) begin
         adv = id_valid && !st[k] && !ex_flush;
         m_s1[k]  = adv ? fwd(k, int'(id_src1), id_src1_used) : 0;
         m_s2[k]  = adv ? fwd(k, int'(id_src2), id_src2_used) : 0;
         m_bub[k] = adv ? 0 : 1;
         if (st[k] && m_cnt[k] < CMAX[k]) m_cnt[k]++;
         if (ex_flush)         m_left[k] = 0;
         else if (m_left[k] > 0) m_left[k]--;
         else if (h[k])        m_left[k] = NN[k] - 1;
         m_mem[k] = m_ex[k];
         m_ex[k].v   = adv;
         m_ex[k].dst = int'(id_dst);
         m_ex[k].wr  = id_wr_en;
         m_ex[k].ld  = id_is_load;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("alu_src1[%0d]", k), int'(src1_o[k]), m_s1[k]);
         chk($sformatf("alu_src2[%0d]", k), int'(src2_o[k]), m_s2[k]);
         chk($sformatf("ex_bubble[%0d]", k), int'(bub_o[k]), m_bub[k]);
         chk($sformatf("stall_cycles[%0d]", k), obs_cnt(k), m_cnt[k]);
      end
   endtask

   // Asynchronous reset: outputs are checked before any clock edge.
   task automatic do_reset();
      rst = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_stall[%0d]", k), int'(stall_o[k]), 0);
         chk($sformatf("rst_src1[%0d]", k), int'(src1_o[k]), 0);
         chk($sformatf("rst_src2[%0d]", k), int'(src2_o[k]), 0);
         chk($sformatf("rst_bubble[%0d]", k), int'(bub_o[k]), 0);
         chk($sformatf("rst_cnt[%0d]", k), obs_cnt(k), 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // LDD R2, then ADD R3,R2,R2 held in ID for `hold` cycles
   task automatic load_use(input int hold);
      set_id(1, 0, 0, 0, 0, 2, 1, 1, 0);
      step();
      set_id(1, 2, 1, 2, 1, 3, 1, 0, 0);
      for (int i = 0; i < hold; i++) step();
   endtask

   initial begin
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #1;
      do_reset();

      // ALU result forwarded from EX
      set_id(1, 2, 1, 3, 1, 1, 1, 0, 0); step();   // ADD R1,R2,R3
      set_id(1, 1, 1, 3, 1, 2, 1, 0, 0); step();   // ADD R2,R1,R3
      chk("t1_src1", int'(src1_o[0]), 1);
      chk("t1_src2", int'(src2_o[0]), 0);

      // ALU result forwarded from MEM across a NOP
      set_id(1, 2, 1, 3, 1, 1, 1, 0, 0); step();   // ADD R1
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); step();   // NOP
      set_id(1, 5, 1, 1, 1, 4, 1, 0, 0); step();   // SUB R4,R5,R1
      chk("t2_src1", int'(src1_o[0]), 0);
      chk("t2_src2", int'(src2_o[0]), 2);

      // Load-use: N=1 and N=3 on the same stream
      do_reset();
      set_id(1, 0, 0, 0, 0, 2, 1, 1, 0); step();
      set_id(1, 2, 1, 2, 1, 3, 1, 0, 0);
      step();
      chk("t3_stall_n1", last_stall[0], 1);
      chk("t3_bubble_n1", int'(bub_o[0]), 1);
      step();
      chk("t3_src1_n1", int'(src1_o[0]), 2);
      chk("t3_src2_n1", int'(src2_o[0]), 2);
      chk("t3_cnt_n1", int'(cnt0), 1);
      step();
      chk("t4_stall3_n3", last_stall[1], 1);
      step();
      chk("t4_stall4_n3", last_stall[1], 0);
      chk("t4_src1_n3", int'(src1_o[1]), 0);
      chk("t4_src2_n3", int'(src2_o[1]), 0);
      chk("t4_cnt_n3", int'(cnt1), 3);

      // Flush in the hazard cycle
      do_reset();
      set_id(1, 0, 0, 0, 0, 2, 1, 1, 0); step();
      set_id(1, 2, 1, 2, 1, 3, 1, 0, 1); step();
      chk("t5_stall_n1", last_stall[0], 0);
      chk("t5_stall_n3", last_stall[1], 0);
      chk("t5_bubble_n3", int'(bub_o[1]), 1);
      set_id(1, 2, 1, 2, 1, 3, 1, 0, 0); step();
      chk("t5_idle_n3", last_stall[1], 0);

      // Flush in the second stall cycle of N=3
      do_reset();
      load_use(1);
      set_id(1, 2, 1, 2, 1, 3, 1, 0, 1); step();
      chk("t5b_flush_n3", last_stall[1], 0);
      set_id(1, 2, 1, 2, 1, 3, 1, 0, 0); step();
      chk("t5b_after_n3", last_stall[1], 0);

      // Counter saturation, then reset in the middle of a stall
      do_reset();
      for (int i = 0; i < 6; i++) load_use(4);
      chk("t6_sat", int'(cnt2), 15);
      chk("t6_cnt_n3", int'(cnt1), 18);
      chk("t6_cnt_n1", int'(cnt0), 6);
      load_use(1);
      #1;
      chk("t6_pre_rst_stall", int'(stall_o[1]), 1);
      do_reset();

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         set_id($urandom_range(0, 9) < 8,
                $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
